lcd_frame_sequencer: RTL and testbench

Parametrised power-up and frame-upload sequencer for the Nokia 5110 path. It drives the screen_controller line-write port and the LCD RST/SCE pins. It holds the panel in reset for a programmable time and loads a frame from a synchronous source memory, replicating source rows across lines. It then releases reset and enables the controller, and can optionally re-upload frames continuously. It replaces the fixed counter logic in the board top level.

---
 rtl/lcd_frame_sequencer.sv | 117 +++++++++++
 tb/tb_lcd_frame_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/lcd_frame_sequencer.sv
// rtl/lcd_frame_sequencer.sv - Nokia 5110 power-up and frame-upload sequencer
// Holds the panel in reset, streams replicated source rows into screen_controller, then releases the panel.
module lcd_frame_sequencer #(
  parameter int LINES         = 84,
  parameter int ADDR_W        = 7,
  parameter int LINE_BITS     = 48,
  parameter int REP_LOG2      = 2,
  parameter int SRC_ADDR_W    = 5,
  parameter int RESET_CYCLES  = 1048576,
  parameter int SETTLE_CYCLES = 66060288,
  parameter int GAP_CYCLES    = 4096
) (
  input  logic                  clk_main,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  continuous,
  output logic [SRC_ADDR_W-1:0] src_addr,
  input  logic [LINE_BITS-1:0]  src_data,
  output logic [ADDR_W-1:0]     ctrl_address,
  output logic [LINE_BITS-1:0]  ctrl_data,
  output logic                  ctrl_wr_en,
  output logic                  ctrl_enable,
  output logic                  lcd_rst,
  output logic                  lcd_sce,
  output logic                  busy,
  output logic                  frame_done,
  output logic [15:0]           frame_count
);
  localparam int MAX_A   = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES;
  localparam int MAX_CYC = (MAX_A > GAP_CYCLES) ? MAX_A : GAP_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam int LW      = $clog2(LINES + 1);

  typedef enum logic [2:0] {IDLE, HOLD, LOAD, SETTLE, RUN} state_t;

  state_t              state, state_next;
  logic [CW-1:0]       cnt;
  logic [LW-1:0]       line;
  logic                timer_done, line_last, issue, timing;
  logic                panel_up, sce_n, cont_q, wr_q;
  logic [ADDR_W-1:0]   addr_q;

  // One shared timer serves HOLD, SETTLE and the continuous-mode gap in RUN.
  always_comb begin
    timer_done = 1'b0;
    case (state)
      HOLD:    timer_done = (cnt == CW'(RESET_CYCLES - 1));
      SETTLE:  timer_done = (cnt == CW'(SETTLE_CYCLES - 1));
      RUN:     timer_done = cont_q && (cnt == CW'(GAP_CYCLES - 1));
      default: timer_done = 1'b0;
    endcase
  end

  assign line_last = (line == LW'(LINES));
  assign issue     = (state == LOAD) && !line_last;
  assign timing    = (state == HOLD) || (state == SETTLE) || ((state == RUN) && cont_q);

  always_ff @(posedge clk_main) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = HOLD;
      HOLD:    if (timer_done) state_next = LOAD;
      LOAD:    if (line_last) state_next = !panel_up ? SETTLE : (continuous ? RUN : IDLE);
      SETTLE:  if (timer_done) state_next = RUN;
      RUN:     if (timer_done) state_next = LOAD;
      default: state_next = IDLE;
    endcase
  end

  // The line counter runs one step past the last line so the final write can drain.
  always_ff @(posedge clk_main) begin
    if (!rst_n) begin
      cnt         <= '0;
      line        <= '0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      frame_done  <= 1'b0;
      frame_count <= '0;
      cont_q      <= 1'b0;
      sce_n       <= 1'b1;
      panel_up    <= 1'b0;
    end else begin
      cnt        <= (timing && (state_next == state)) ? cnt + 1'b1 : '0;
      line       <= issue ? line + 1'b1 : '0;
      wr_q       <= issue;
      addr_q     <= issue ? ADDR_W'(line) : '0;
      frame_done <= (state == LOAD) && line_last;
      if ((state == LOAD) && line_last) begin
        frame_count <= frame_count + 16'd1;
        cont_q      <= continuous;
      end
      // A fresh start from IDLE runs the full power-up sequence again.
      if ((state == IDLE) && start) begin
        sce_n    <= 1'b0;
        panel_up <= 1'b0;
      end
      if ((state == SETTLE) && timer_done) panel_up <= 1'b1;
    end
  end

  always_comb begin
    busy      = (state != IDLE) && (state != RUN);
    src_addr  = issue ? SRC_ADDR_W'(line >> REP_LOG2) : '0;
    ctrl_data = wr_q ? src_data : '0;
  end

  assign ctrl_wr_en   = wr_q;
  assign ctrl_address = addr_q;
  assign lcd_rst      = panel_up;
  assign ctrl_enable  = panel_up;
  assign lcd_sce      = sce_n;
endmodule

// File: tb/tb_lcd_frame_sequencer.sv
// tb/tb_lcd_frame_sequencer.sv - randomized self-checking bench for lcd_frame_sequencer
// Two instances: the 84-line default geometry and a 10-line, no-replication geometry.
module tb_lcd_frame_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, cont;
  logic [4:0]  src_addr;
  logic [47:0] src_data;
  logic [6:0]  ctrl_address;
  logic [47:0] ctrl_data;
  logic        wr, en, lrst, sce, busy, fd;
  logic [15:0] fcnt;

  logic        rst2, start2, cont2;
  logic [3:0]  src_addr2;
  logic [47:0] src_data2;
  logic [3:0]  ctrl_address2;
  logic [47:0] ctrl_data2;
  logic        wr2, en2, lrst2, sce2, busy2, fd2;
  logic [15:0] fcnt2;

  lcd_frame_sequencer #(.LINES(84), .ADDR_W(7), .LINE_BITS(48), .REP_LOG2(2), .SRC_ADDR_W(5),
    .RESET_CYCLES(8), .SETTLE_CYCLES(16), .GAP_CYCLES(4)) dut (
    .clk_main(clk), .rst_n(rst_n), .start(start), .continuous(cont),
    .src_addr(src_addr), .src_data(src_data), .ctrl_address(ctrl_address), .ctrl_data(ctrl_data),
    .ctrl_wr_en(wr), .ctrl_enable(en), .lcd_rst(lrst), .lcd_sce(sce), .busy(busy),
    .frame_done(fd), .frame_count(fcnt));

  lcd_frame_sequencer #(.LINES(10), .ADDR_W(4), .LINE_BITS(48), .REP_LOG2(0), .SRC_ADDR_W(4),
    .RESET_CYCLES(8), .SETTLE_CYCLES(16), .GAP_CYCLES(4)) dut2 (
    .clk_main(clk), .rst_n(rst2), .start(start2), .continuous(cont2),
    .src_addr(src_addr2), .src_data(src_data2), .ctrl_address(ctrl_address2), .ctrl_data(ctrl_data2),
    .ctrl_wr_en(wr2), .ctrl_enable(en2), .lcd_rst(lrst2), .lcd_sce(sce2), .busy(busy2),
    .frame_done(fd2), .frame_count(fcnt2));

  function automatic logic [47:0] row(input int r);
    logic [47:0] v;
    v = {48{r[0]}};
    return v ^ 48'(r);
  endfunction

  // Synchronous source memories: data one cycle after the address.
  always @(posedge clk) src_data  <= row(int'(src_addr));
  always @(posedge clk) src_data2 <= row(int'(src_addr2));

  int n_tests = 0, n_fail = 0;
  int exp_idx = 0, n_wr = 0, n_fd = 0, exp_idx2 = 0, n_wr2 = 0, n_fd2 = 0, cyc = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Every observed write is checked against the next expected line of the frame.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (wr) begin
      check("wr_addr", 64'(ctrl_address), 64'(exp_idx));
      check("wr_data", 64'(ctrl_data), 64'(row(exp_idx >> 2)));
      exp_idx = (exp_idx + 1) % 84;
      n_wr++;
    end
    if (fd) n_fd++;
    if (wr2) begin
      check("wr2_addr", 64'(ctrl_address2), 64'(exp_idx2));
      check("wr2_data", 64'(ctrl_data2), 64'(row(exp_idx2)));
      exp_idx2 = (exp_idx2 + 1) % 10;
      n_wr2++;
    end
    if (fd2) n_fd2++;
  endtask

  task automatic check_reset_outputs();
    check("rst_lcd_rst", 64'(lrst), 64'(0));
    check("rst_lcd_sce", 64'(sce), 64'(1));
    check("rst_enable", 64'(en), 64'(0));
    check("rst_wr_en", 64'(wr), 64'(0));
    check("rst_address", 64'(ctrl_address), 64'(0));
    check("rst_data", 64'(ctrl_data), 64'(0));
    check("rst_src_addr", 64'(src_addr), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_frame_done", 64'(fd), 64'(0));
    check("rst_frame_count", 64'(fcnt), 64'(0));
  endtask

  int low, busy_bad, upl, last_cyc, gap, en_seen, en_drop, hit, up2;

  initial begin
    rst_n = 0; start = 0; cont = 0; rst2 = 0; start2 = 0; cont2 = 0;
    repeat (3) tick();
    check_reset_outputs();

    // Power-up with random start pulses that must all be ignored.
    rst_n = 1; tick();
    exp_idx = 0; n_wr = 0; n_fd = 0;
    start = 1; tick(); start = 0;
    low = 0; busy_bad = 0;
    for (int i = 0; i < 400 && !lrst; i++) begin
      low++;
      if (!busy) busy_bad++;
      start = ($urandom_range(3) == 0);
      tick();
    end
    start = 0;
    check("rst_low_cycles", 64'(low), 64'(8 + 85 + 16));
    check("busy_during_seq", 64'(busy_bad), 64'(0));
    check("enable_with_rst", 64'(en), 64'(1));
    check("sce_low", 64'(sce), 64'(0));
    check("run_not_busy", 64'(busy), 64'(0));
    check("frame1_writes", 64'(n_wr), 64'(84));
    check("frame1_done", 64'(n_fd), 64'(1));
    check("frame1_count", 64'(fcnt), 64'(1));
    for (int i = 0; i < 20; i++) begin
      start = $urandom_range(1);
      tick();
    end
    start = 0;
    check("run_start_ignored", 64'(n_wr), 64'(84));
    check("run_count_stable", 64'(fcnt), 64'(1));

    // Continuous mode: three uploads, the last ending non-continuous.
    rst_n = 0; tick(); rst_n = 1;
    exp_idx = 0; n_wr = 0; n_fd = 0;
    upl = 0; last_cyc = 0; gap = -1; en_seen = 0; en_drop = 0;
    cont = 1; start = 1; tick(); start = 0;
    for (int i = 0; i < 3000 && n_fd < 3; i++) begin
      tick();
      if (en) en_seen = 1;
      else if (en_seen) en_drop = 1;
      if (wr && ctrl_address == 7'd0 && upl == 2) gap = cyc - last_cyc - 1;
      if (wr && ctrl_address == 7'd83) begin
        upl++;
        last_cyc = cyc;
        cont = (upl < 3);
      end else begin
        cont = $urandom_range(1);
      end
    end
    repeat (10) tick();
    check("cont_frames", 64'(fcnt), 64'(3));
    check("cont_done_pulses", 64'(n_fd), 64'(3));
    check("cont_writes", 64'(n_wr), 64'(252));
    check("cont_gap", 64'(gap), 64'(4 + 1));
    check("cont_enable_kept", 64'({en_seen[0], en_drop[0]}), 64'(2'b10));
    check("cont_idle_rst_hi", 64'(lrst), 64'(1));
    check("cont_idle_busy", 64'(busy), 64'(0));

    // Reset in the middle of an upload, then a full clean upload.
    rst_n = 0; tick(); rst_n = 1; tick();
    exp_idx = 0; n_wr = 0; n_fd = 0; hit = 0; cont = 0;
    start = 1; tick(); start = 0;
    for (int i = 0; i < 500 && !hit; i++) begin
      tick();
      if (wr && ctrl_address == 7'd40) hit = 1;
    end
    check("midload_reached", 64'(hit), 64'(1));
    rst_n = 0; tick();
    check_reset_outputs();
    check("midload_no_done", 64'(n_fd), 64'(0));
    rst_n = 1; exp_idx = 0; n_wr = 0;
    start = 1; tick(); start = 0;
    for (int i = 0; i < 400 && !lrst; i++) tick();
    check("reload_writes", 64'(n_wr), 64'(84));
    check("reload_done", 64'(n_fd), 64'(1));
    check("reload_count", 64'(fcnt), 64'(1));

    // start coinciding with reset must leave the sequencer idle.
    rst_n = 0; start = 1; tick(); rst_n = 1; start = 0;
    repeat (5) tick();
    check("start_in_reset_busy", 64'(busy), 64'(0));
    check("start_in_reset_sce", 64'(sce), 64'(1));
    check("start_in_reset_cnt", 64'(fcnt), 64'(0));

    // Ten-line geometry without replication: two uploads.
    rst2 = 0; tick(); rst2 = 1;
    exp_idx2 = 0; n_wr2 = 0; n_fd2 = 0; up2 = 0;
    cont2 = 1; start2 = 1; tick(); start2 = 0;
    for (int i = 0; i < 1000 && n_fd2 < 2; i++) begin
      tick();
      if (wr2 && ctrl_address2 == 4'd9) begin
        up2++;
        cont2 = (up2 < 2);
      end else begin
        cont2 = $urandom_range(1);
      end
    end
    repeat (10) tick();
    check("g10_writes", 64'(n_wr2), 64'(20));
    check("g10_done", 64'(n_fd2), 64'(2));
    check("g10_count", 64'(fcnt2), 64'(2));
    check("g10_idle", 64'(busy2), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
